writeback_arbiter: RTL
======================

// Module: writeback_arbiter
// PURPOSE
//  Owns the register file's single write port. Merges two write sources:
//  - the pipeline W-stage write, which always wins and is never stalled;
//  - multi-cycle multdiv results, which are buffered in a small FIFO.
//  Drives the regfile write controls. Exports a busy mask of registers with
//  queued writes, so the hazard unit can stall readers.
// PARAMETERS
//  DEPTH   2   multdiv result FIFO entries (>=1)
//  DATA_W  32  write data width
//  ADDR_W  5   register index width (32 regs)
// PORTS
//  clock         in   1       rising-edge clock
//  ctrl_reset_n  in   1       reset; asynchronous, active-low
//  pipe_we       in   1       W-stage write request
//  pipe_rd       in   ADDR_W  W-stage destination register
//  pipe_data     in   DATA_W  W-stage write data
//  md_valid      in   1       multdiv result offered
//  md_rd         in   ADDR_W  multdiv destination register
//  md_data       in   DATA_W  multdiv result
//  md_ready      out  1       FIFO can accept; transfer = md_valid & md_ready
//  wb_we         out  1       to regfile ctrl_writeEnable
//  wb_rd         out  ADDR_W  to regfile ctrl_writeReg
//  wb_data       out  DATA_W  to regfile data_writeReg
//  busy_mask     out  32      bit r=1 while a live queued entry targets r
// BEHAVIOUR
//  - Reset (ctrl_reset_n=0): FIFO emptied and all entries invalid.
//    Outputs forced: wb_we=0, wb_rd=0, wb_data=0, busy_mask=0, md_ready=0.
//    Reset may assert mid-operation; queued results are discarded.
//  - pipe_live = pipe_we & (pipe_rd!=0). A write to r0 is a no-op and
//    frees the port.
//  - Port select, combinational, same cycle:
//    1. If pipe_live: wb_* = pipe_*.
//    2. Else if a FIFO head exists: wb_* = head; head pops at the clock edge.
//       A killed head pops with wb_we=0.
//    3. Else if the offered md result transfers and the FIFO is empty:
//       bypass with wb_* = md_*, zero latency, not enqueued.
//    4. Otherwise wb_we=0.
//  - Enqueue: a transfer that is not bypassed is written at the tail at the
//    clock edge. An md_rd of 0 is accepted and dropped.
//  - md_ready = (count < DEPTH). Registered-state only; it does not depend
//    on a same-cycle pop.
//  - Push and pop in the same cycle: count is unchanged; FIFO order is kept.
//  - WAW kill: pipeline writes are always younger than multdiv results.
//    - When pipe_live, every queued entry with rd==pipe_rd is marked
//      killed at the edge.
//    - A same-cycle transfer with md_rd==pipe_rd is accepted and killed.
//    - Killed entries still drain in order but never assert wb_we.
//  - busy_mask: OR of one-hot(rd) over valid, unkilled entries. Bit 0 is
//    always 0. Updates at the edge after push, pop or kill.
//  - Max wait for a queued entry: DEPTH idle pipe cycles.
//  - Pointers wrap modulo DEPTH; count is held in clog2(DEPTH+1) bits.
// STRUCTURE
//  - Shared package: ADDR_W, DATA_W, the wb_req_t struct {we, rd, data},
//    and the reg-index constant R0=0.
//  - Sub-module md_result_fifo: entries {valid, killed, rd, data} plus
//    head/tail/count. It exposes a kill-by-rd port and a live-rd mask.
//  - Top level: priority mux and bypass logic only.
// TESTING
//  1. Reset: assert ctrl_reset_n=0 with 2 queued entries
//     -> wb_we=0, busy_mask=0, md_ready=0.
//     Release -> md_ready=1.
//  2. Bypass: FIFO empty, pipe_we=0, md offers r5=0x1234
//     -> same cycle wb_we=1, wb_rd=5, wb_data=0x1234; busy_mask stays 0.
//  3. Conflict: pipe writes r3 while md offers r7=0xAA
//     -> r7 queued, busy_mask[7]=1.
//     Next idle cycle -> wb r7=0xAA; busy_mask=0 the cycle after.
//  4. Full: pipe busy 3 cycles, md offers r8, r9, r10
//     -> r8 and r9 accepted, md_ready=0 on the third cycle.
//     Pipe idles -> r8 then r9 drain in order.
//  5. WAW kill: r4 queued, then pipe writes r4=0x55
//     -> busy_mask[4] clears; the head pops later with wb_we=0.
//     Regfile r4 remains 0x55.
//  6. r0 handling: pipe_we=1, pipe_rd=0 with r6 queued
//     -> r6 drains that same cycle.
//     An md_rd=0 transfer -> never writes.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   ADDR_W / DATA_W : default register index and data widths
//   wb_req_t        : one regfile write request {we, rd, data}
//   R0              : index of the hard-wired zero register
package writeback_arbiter_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned R0     = 0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_md_result_fifo.sv
// Small in-order FIFO holding multdiv results that could not use the write
// port immediately. Each entry carries a killed flag so a younger pipeline
// write to the same register can cancel it without reordering the queue.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i            : enqueue {push_rd_i, push_data_i}, killed if push_killed_i
//   pop_i             : drop the head entry
//   kill_en_i/rd_i    : mark every queued entry targeting kill_rd_i as killed
//   head_*_o          : head entry view (head_valid_o = FIFO non-empty)
//   ready_o           : count < DEPTH
//   live_mask_o       : one-hot OR of rd over valid, unkilled entries
module md_result_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              push_killed_i,
    input  logic [ADDR_W-1:0] push_rd_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_en_i,
    input  logic [ADDR_W-1:0] kill_rd_i,
    output logic              head_valid_o,
    output logic              head_killed_o,
    output logic [ADDR_W-1:0] head_rd_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              ready_o,
    output logic [31:0]       live_mask_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             killed_q, killed_d;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [PtrW-1:0]              head_q, head_d;
    logic [PtrW-1:0]              tail_q, tail_d;
    logic [CntW-1:0]              count_q, count_d;
    logic                         do_push, do_pop;

    assign do_push = push_i && (count_q < CntFull);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        valid_d  = valid_q;
        killed_d = killed_q;
        rd_d     = rd_q;
        data_d   = data_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);

        if (kill_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (rd_q[i] == kill_rd_i)) begin
                    killed_d[i] = 1'b1;
                end
            end
        end

        if (do_pop) begin
            valid_d[head_q]  = 1'b0;
            killed_d[head_q] = 1'b0;
            head_d           = (head_q == PtrLast) ? '0 : head_q + 1'b1;
        end

        // Push never lands on the head slot being popped: push needs a free
        // slot and pop needs an occupied one, so they index different entries.
        if (do_push) begin
            valid_d[tail_q]  = 1'b1;
            killed_d[tail_q] = push_killed_i;
            rd_d[tail_q]     = push_rd_i;
            data_d[tail_q]   = push_data_i;
            tail_d           = (tail_q == PtrLast) ? '0 : tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            killed_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            killed_q <= killed_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    assign head_valid_o  = (count_q != '0);
    assign head_killed_o = killed_q[head_q];
    assign head_rd_o     = rd_q[head_q];
    assign head_data_o   = data_q[head_q];
    assign ready_o       = (count_q < CntFull);

    always_comb begin
        live_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !killed_q[i]) begin
                for (int r = R0 + 1; r < 32; r++) begin
                    if (rd_q[i] == ADDR_W'(r)) begin
                        live_mask_o[r] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Owner of the register file's single write port. The W-stage write always
// wins; multdiv results either bypass straight to the port (FIFO empty, port
// free) or wait in md_result_fifo. busy_mask flags registers with pending
// queued writes so the hazard unit can stall readers.
//   clock, ctrl_reset_n          : clock, asynchronous active-low reset
//   pipe_we/pipe_rd/pipe_data    : W-stage write request
//   md_valid/md_rd/md_data       : multdiv result offer, md_ready handshake
//   wb_we/wb_rd/wb_data          : regfile write controls
//   busy_mask                    : registers targeted by live queued entries
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = writeback_arbiter_pkg::DATA_W,
    parameter int unsigned ADDR_W = writeback_arbiter_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       busy_mask
);

    localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(R0);

    logic              pipe_live;
    logic              md_xfer;
    logic              bypass;
    logic              fifo_push, fifo_pop, fifo_ready;
    logic              head_valid, head_killed;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic [31:0]       live_mask;

    assign pipe_live = pipe_we && (pipe_rd != RegZero);
    // Readiness comes from registered occupancy only, never from a same-cycle pop.
    assign md_ready  = fifo_ready && ctrl_reset_n;
    assign md_xfer   = md_valid && md_ready;

    always_comb begin
        wb_we    = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        if (ctrl_reset_n) begin
            if (pipe_live) begin
                wb_we   = 1'b1;
                wb_rd   = pipe_rd;
                wb_data = pipe_data;
            end else if (head_valid) begin
                // A killed head still takes its turn, just without writing.
                fifo_pop = 1'b1;
                wb_we    = !head_killed;
                wb_rd    = head_rd;
                wb_data  = head_data;
            end else if (md_xfer) begin
                bypass = 1'b1;
                if (md_rd != RegZero) begin
                    wb_we   = 1'b1;
                    wb_rd   = md_rd;
                    wb_data = md_data;
                end
            end
        end
    end

    // r0 results are accepted on the handshake but never stored.
    assign fifo_push = md_xfer && !bypass && (md_rd != RegZero);

    md_result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i         (clock),
        .rst_ni        (ctrl_reset_n),
        .push_i        (fifo_push),
        .push_killed_i (pipe_live && (md_rd == pipe_rd)),
        .push_rd_i     (md_rd),
        .push_data_i   (md_data),
        .pop_i         (fifo_pop),
        .kill_en_i     (pipe_live),
        .kill_rd_i     (pipe_rd),
        .head_valid_o  (head_valid),
        .head_killed_o (head_killed),
        .head_rd_o     (head_rd),
        .head_data_o   (head_data),
        .ready_o       (fifo_ready),
        .live_mask_o   (live_mask)
    );

    assign busy_mask = ctrl_reset_n ? live_mask : '0;

endmodule
